// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and related schedulers.
// Burst locking is enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_B = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width needed to index 'value' items; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; the arbiter uses the slave modport.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int B = DEFAULT_B
);

  localparam int IDW = clog2(N);

  logic [N-1:0]   req;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_wr;
  logic [B-1:0]   fifo_wdata;
  logic [IDW-1:0] grant_id;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_wr, fifo_wdata, grant_id
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_wr, fifo_wdata, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rotated;
  int           pos;
  int           sum;

  always_comb begin
    // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate the index back.
    rotated = N'({req, req} >> ptr);
    valid   = |rotated;
    pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) pos = k;
    end
    sum = pos + int'(ptr);
    if (sum >= N) sum = sum - N;
    idx = IDW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N producers.
// Define FIFO_ARB_BURST_EN to let a granted producer keep the port for up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int B         = DEFAULT_B,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDW = clog2(N);

  if (N < 2 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: N must be >= 2 and MAX_BURST >= 1");
  end

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (int'(i) >= N - 1) return '0;
    return i + 1'b1;
  endfunction

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_ptr;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           cand_valid;
  logic [IDW-1:0] cand_idx;
  logic           accept;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Outputs stay quiet throughout reset even if producers are requesting.
  assign accept = cand_valid & ~bus.fifo_full & ~rst;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = clog2(MAX_BURST + 1);

  arb_state_t     state, state_next;
  logic [IDW-1:0] lock_id, lock_next;
  logic [IDW-1:0] ptr_next;
  logic [CW-1:0]  burst_cnt, cnt_next;
  logic           hold_lock;

  // A dropped lock request hands the port straight back to round-robin after the lock owner.
  always_comb begin
    pick_ptr  = rr_ptr;
    hold_lock = 1'b0;
    if (state == BURST) begin
      if (bus.req[lock_id]) hold_lock = 1'b1;
      else                  pick_ptr  = next_idx(lock_id);
    end
    cand_valid = hold_lock | pick_valid;
    cand_idx   = hold_lock ? lock_id : pick_idx;
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_id;
    cnt_next   = burst_cnt;
    ptr_next   = rr_ptr;
    if (hold_lock) begin
      if (accept) begin
        if (int'(burst_cnt) + 1 >= MAX_BURST) begin
          state_next = IDLE;
          cnt_next   = '0;
          ptr_next   = next_idx(lock_id);
        end else begin
          cnt_next = burst_cnt + 1'b1;
        end
      end
    end else begin
      if (state == BURST) begin
        state_next = IDLE;
        cnt_next   = '0;
        ptr_next   = next_idx(lock_id);
      end
      if (accept) begin
        ptr_next = next_idx(cand_idx);
        if (MAX_BURST > 1) begin
          state_next = BURST;
          lock_next  = cand_idx;
          cnt_next   = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_id   <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      lock_id   <= lock_next;
      burst_cnt <= cnt_next;
      rr_ptr    <= ptr_next;
    end
  end
`else
  assign pick_ptr   = rr_ptr;
  assign cand_valid = pick_valid;
  assign cand_idx   = pick_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= '0;
    else if (accept) rr_ptr <= next_idx(cand_idx);
  end
`endif

  always_comb begin
    bus.ack        = '0;
    bus.fifo_wdata = '0;
    bus.grant_id   = '0;
    if (accept) begin
      bus.ack[cand_idx] = 1'b1;
      bus.fifo_wdata    = bus.req_data[cand_idx*B +: B];
      bus.grant_id      = cand_idx;
    end
  end

  assign bus.fifo_wr = accept;

endmodule
